mips_data_bus_bridge: RTL and testbench
=======================================

Name: mips_data_bus_bridge

Overview:
- Sits between the Harvard CPU data port and a variable-latency word-addressed data memory.
- The CPU expects a combinational read and a single-cycle write. The bridge converts each CPU access into a req/gnt/rvalid memory transaction.
- While a transaction is in flight, the bridge stalls the CPU by gating its clk_enable.
- On completion, it presents the read data and releases the CPU for exactly one cycle.

Parameters:
- TIMEOUT, 64: max cycles spent in REQ+WAIT_R before the access is aborted.
- ERR_DATA, 32'hDEADBEEF: read data returned on a timed-out read.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clk_enable_in  in  1  testbench/system enable
- cpu_clk_enable  out  1  enable driven to the CPU clk_enable
- cpu_address  in  32  CPU data_address
- cpu_read  in  1  CPU data_read
- cpu_write  in  1  CPU data_write
- cpu_writedata  in  32  CPU data_writedata
- cpu_readdata  out  32  to CPU data_readdata
- mem_req  out  1  transaction request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  32  {cpu_address[31:2],2'b00}
- mem_wdata  out  32  write data
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- bus_err  out  1  sticky: a timeout occurred
- proto_err  out  1  sticky: cpu_read and cpu_write were asserted together
- stall_cycles  out  32  saturating count of cycles with cpu_clk_enable=0 while clk_enable_in=1

Behaviour:
- Reset:
  - State goes to IDLE.
  - mem_req=0, mem_we=0, cpu_readdata=0, bus_err=0, proto_err=0, stall_cycles=0, timeout counter=0.
  - Any in-flight transaction is dropped. The memory is reset by the same reset; mem_rvalid is ignored in IDLE and DONE.
- cpu_clk_enable = clk_enable_in & ready.
  - ready=1 in IDLE when neither cpu_read nor cpu_write is asserted.
  - ready=1 in DONE.
  - ready=0 otherwise.
- State IDLE:
  - If clk_enable_in & (cpu_read|cpu_write): latch address, writedata, and we=cpu_write (write wins if both asserted; also set proto_err), then go to REQ.
  - The latch happens on the same edge the CPU is stalled, so the CPU never commits the instruction that cycle.
- State REQ:
  - mem_req=1, with mem_addr/mem_wdata/mem_we taken from the latches.
  - If mem_gnt: a write goes to DONE; a read goes to WAIT_R.
  - mem_req drops the cycle after gnt.
- State WAIT_R:
  - mem_req=0.
  - If mem_rvalid: capture mem_rdata into cpu_readdata and go to DONE.
  - rvalid arriving in the same cycle as gnt is not legal; the memory guarantees latency of at least 1.
- State DONE:
  - cpu_clk_enable=clk_enable_in and cpu_readdata is held.
  - If clk_enable_in: go to IDLE.
  - If clk_enable_in=0: stay in DONE, so the CPU is guaranteed to see one enabled edge with valid data.
- Timeout:
  - The counter increments every cycle in REQ or WAIT_R and clears on entering IDLE.
  - On reaching TIMEOUT: set bus_err, set cpu_readdata=ERR_DATA (reads only), drop mem_req, go to DONE.
  - Timeout takes priority over a gnt/rvalid in the same cycle.
- cpu_readdata retains its last value in IDLE. The CPU only samples it while enabled in DONE.
- stall_cycles saturates at 32'hFFFFFFFF.
- Minimum read latency: 3 stalled cycles (IDLE, REQ with gnt, WAIT_R with rvalid), followed by DONE.

Decomposition:
- Shared package mips_bus_pkg holds:
  - bridge_state_t enum {IDLE, REQ, WAIT_R, DONE}
  - ERR_DATA default constant
  - WORD_MASK constant
- One sub-module: bridge_timeout_ctr. It takes TIMEOUT, clear, and enable inputs and produces an expired output.

Test Plan:
- Read at 0x0000_1006, gnt on 1st REQ cycle, rvalid 2 cycles later with 0x12345678:
  - mem_addr=0x0000_1004 and mem_we=0.
  - cpu_clk_enable is low for 4 cycles, then high for 1 cycle in DONE with cpu_readdata=0x12345678.
  - stall_cycles=4.
- Write 0xCAFEBABE to 0x20 with gnt delayed 3 cycles:
  - mem_req held for 4 cycles with stable addr/wdata and mem_we=1.
  - DONE follows, then IDLE; no rvalid is required.
- Read with no gnt ever, TIMEOUT=8:
  - After 8 cycles bus_err=1 and cpu_readdata=0xDEADBEEF.
  - CPU released for one cycle; bus_err stays high on later good accesses.
- cpu_read=cpu_write=1:
  - proto_err=1 and the transaction is a write.
- Reset asserted in WAIT_R, then a stale rvalid arrives:
  - The bridge is in IDLE and cpu_readdata stays 0.
  - The next read completes normally.
- clk_enable_in=0 during DONE for 3 cycles:
  - The bridge stays in DONE with data held.
  - cpu_clk_enable follows clk_enable_in, and the bridge returns to IDLE on the first enabled edge.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU data-port to req/gnt/rvalid memory bridge.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } bridge_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Counts cycles while enabled; expired flags the TIMEOUT-th enabled cycle.
module bridge_timeout_ctr #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current cycle is the TIMEOUT-th one spent enabled.
  assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mips_data_bus_bridge.sv
// Converts combinational-read / single-cycle-write CPU data accesses into
// req/gnt/rvalid memory transactions, stalling the CPU via clk_enable.
module mips_data_bus_bridge
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable_in,
  output logic        cpu_clk_enable,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        proto_err,
  output logic [31:0] stall_cycles
);

  bridge_state_t state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          bus_err_q, bus_err_d;
  logic          proto_err_q, proto_err_d;
  logic [31:0]   stall_q, stall_d;

  logic ready;
  logic busy;
  logic expired;

  assign busy  = (state_q == REQ) || (state_q == WAIT_R);
  assign ready = ((state_q == IDLE) && !(cpu_read || cpu_write)) || (state_q == DONE);

  bridge_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (!busy),
    .enable (busy),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    mem_req_d   = mem_req_q;
    rdata_d     = rdata_q;
    bus_err_d   = bus_err_q;
    proto_err_d = proto_err_q;
    stall_d     = stall_q;

    unique case (state_q)
      IDLE: begin
        if (clk_enable_in && (cpu_read || cpu_write)) begin
          addr_d    = cpu_address & WORD_MASK;
          wdata_d   = cpu_writedata;
          we_d      = cpu_write;
          mem_req_d = 1'b1;
          state_d   = REQ;
          if (cpu_read && cpu_write) begin
            proto_err_d = 1'b1;
          end
        end
      end
      REQ: begin
        // Timeout wins over a grant landing in the same cycle.
        if (expired) begin
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (!we_q) begin
            rdata_d = ERR_DATA;
          end
        end else if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = we_q ? DONE : WAIT_R;
        end
      end
      WAIT_R: begin
        if (expired) begin
          bus_err_d = 1'b1;
          rdata_d   = ERR_DATA;
          state_d   = DONE;
        end else if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        if (clk_enable_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clk_enable_in && !ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      mem_req_q   <= mem_req_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
      proto_err_q <= proto_err_d;
      stall_q     <= stall_d;
    end
  end

  assign cpu_clk_enable = clk_enable_in & ready;
  assign cpu_readdata   = rdata_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign bus_err        = bus_err_q;
  assign proto_err      = proto_err_q;
  assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// Scoreboarded bench: CPU driver + latency-configurable memory responder,
// with decoupled CPU-side and memory-side monitors.
module tb_mips_data_bus_bridge;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  localparam int NEVER = 255;

  logic        clk;
  logic        reset;
  logic        clk_enable_in;
  logic        cpu_clk_enable;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic        proto_err;
  logic [31:0] stall_cycles;

  mips_data_bus_bridge #(
    .TIMEOUT (TO),
    .ERR_DATA(ERR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable_in (clk_enable_in),
    .cpu_clk_enable(cpu_clk_enable),
    .cpu_address   (cpu_address),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_writedata (cpu_writedata),
    .cpu_readdata  (cpu_readdata),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .bus_err       (bus_err),
    .proto_err     (proto_err),
    .stall_cycles  (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] w);
    return (w * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  // ---------------- memory responder ----------------
  logic [31:0] store[logic [31:0]];
  int cfg_d = 0;
  int cfg_l = 1;
  int req_cnt = 0;
  int rv_wait = 0;
  logic [31:0] rv_addr = '0;

  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    if (rv_wait > 0) begin
      rv_wait--;
      if (rv_wait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = store.exists(rv_addr) ? store[rv_addr] : dflt(rv_addr);
      end
    end
    if (mem_req) begin
      if (req_cnt == cfg_d) begin
        mem_gnt = 1'b1;
        if (mem_we) store[mem_addr] = mem_wdata;
        else begin
          rv_wait = cfg_l;
          rv_addr = mem_addr;
        end
      end else begin
        mem_gnt = 1'b0;
      end
      req_cnt++;
    end else begin
      mem_gnt = 1'b0;
      req_cnt = 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        rd_only;
    logic [31:0] rdata;
    int          stall;
    logic        berr;
    logic        perr;
    logic [31:0] stall_total;
  } cpu_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cycles;
  } mem_exp_t;

  cpu_exp_t cq[$];
  mem_exp_t mq[$];
  logic mon_en = 1'b0;

  int stall_run = 0;
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (clk_enable_in && !cpu_clk_enable) stall_run++;
      if (cpu_clk_enable && (cpu_read || cpu_write)) begin
        if (cq.size() == 0) begin
          chk("cpu_unexpected_commit", 32'd1, 32'd0);
        end else begin
          cpu_exp_t e;
          e = cq.pop_front();
          if (e.rd_only) chk("readdata", cpu_readdata, e.rdata);
          chk("stall_len", stall_run, e.stall);
          chk("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
          chk("proto_err", {31'd0, proto_err}, {31'd0, e.perr});
          chk("stall_cycles", stall_cycles, e.stall_total);
        end
        stall_run = 0;
      end
    end
  end

  logic prev_req = 1'b0;
  int req_run = 0;
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (mem_req) begin
        req_run++;
        if (mq.size() == 0) begin
          chk("mem_unexpected_req", 32'd1, 32'd0);
        end else begin
          chk("mem_addr", mem_addr, mq[0].addr);
          chk("mem_we", {31'd0, mem_we}, {31'd0, mq[0].we});
          if (mq[0].we) chk("mem_wdata", mem_wdata, mq[0].wdata);
        end
      end else if (prev_req) begin
        if (mq.size() != 0) begin
          mem_exp_t m;
          m = mq.pop_front();
          chk("req_cycles", req_run, m.cycles);
        end
        req_run = 0;
      end
      prev_req = mem_req;
    end
  end

  // ---------------- reference model + driver ----------------
  logic [31:0] ref_mem[logic [31:0]];
  logic        m_berr = 1'b0;
  logic        m_perr = 1'b0;
  logic [31:0] m_stall = '0;

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // d: grant delay in REQ cycles (NEVER = no grant), l: rvalid latency after grant,
  // hold: cycles clk_enable_in is dropped once the access completes.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int d, input int l, input int hold);
    cpu_exp_t e;
    mem_exp_t m;
    logic [31:0] w;
    logic tout;
    bit found;
    w    = a & 32'hFFFF_FFFC;
    tout = (d >= NEVER) || (wr ? (d + 1 >= TO) : (d + 1 + l >= TO));
    e.rd_only = rd && !wr;
    e.stall   = tout ? 1 + TO : (wr ? 2 + d : 2 + d + l);
    e.rdata   = tout ? ERR : (ref_mem.exists(w) ? ref_mem[w] : dflt(w));
    if (wr && !tout) ref_mem[w] = wd;
    m_berr  = m_berr | tout;
    m_perr  = m_perr | (rd && wr);
    m_stall = m_stall + e.stall;
    e.berr = m_berr;
    e.perr = m_perr;
    e.stall_total = m_stall;
    m.we = wr;
    m.addr = w;
    m.wdata = wd;
    m.cycles = (d + 1 >= TO) ? TO : d + 1;
    cq.push_back(e);
    mq.push_back(m);

    cfg_d = d;
    cfg_l = l;
    cpu_address   = a;
    cpu_read      = rd;
    cpu_write     = wr;
    cpu_writedata = wd;

    if (hold > 0) begin
      repeat (e.stall) @(posedge clk);
      #1 clk_enable_in = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_cpu_clk_enable", {31'd0, cpu_clk_enable}, 32'd0);
        if (e.rd_only) chk("hold_readdata", cpu_readdata, e.rdata);
      end
      @(posedge clk);
      #1 clk_enable_in = 1'b1;
    end

    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (cpu_clk_enable) found = 1;
    end
    if (!found) begin
      chk("release_timeout", 32'd0, 32'd1);
      finish_now();
    end
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clk_enable_in = 1'b1;
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    store[32'h1004]   = 32'h12345678;
    ref_mem[32'h1004] = 32'h12345678;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_readdata", cpu_readdata, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_cpu_clk_enable", {31'd0, cpu_clk_enable}, 32'd1);

    // Reset while waiting for rvalid; the late rvalid must be ignored.
    @(posedge clk);
    #1;
    cfg_d = 0;
    cfg_l = 4;
    cpu_address = 32'h40;
    cpu_read = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cpu_read = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("stale_readdata", cpu_readdata, 32'd0);
    chk("stale_mem_req", {31'd0, mem_req}, 32'd0);
    chk("stale_cpu_clk_enable", {31'd0, cpu_clk_enable}, 32'd1);
    chk("stale_stall_cycles", stall_cycles, 32'd0);
    chk("stale_bus_err", {31'd0, bus_err}, 32'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    access(1, 0, 32'h0000_1006, 32'h0, 0, 2, 0);
    access(0, 1, 32'h0000_0020, 32'hCAFEBABE, 3, 1, 0);
    access(1, 0, 32'h0000_0021, 32'h0, 1, 1, 0);
    access(1, 0, 32'h0000_1004, 32'h0, NEVER, 1, 0);
    access(1, 0, 32'h0000_1004, 32'h0, 0, 1, 0);
    access(1, 1, 32'h0000_0030, 32'h0BADF00D, 1, 1, 0);
    access(1, 0, 32'h0000_0033, 32'h0, 0, 1, 3);
    access(1, 0, 32'h0000_0020, 32'h0, 2, 4, 0);
    access(1, 0, 32'h0000_0020, 32'h0, 3, 4, 0);
    access(0, 1, 32'h0000_0024, 32'h11112222, NEVER, 1, 0);

    for (int i = 0; i < 120; i++) begin
      int r, d, l, hold, kind;
      logic rd, wr;
      logic [31:0] a;
      r    = $urandom_range(0, 99);
      d    = (r < 8) ? NEVER : $urandom_range(0, 3);
      l    = $urandom_range(1, 3);
      hold = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
      kind = $urandom_range(0, 19);
      rd   = (kind < 10) || (kind == 19);
      wr   = (kind >= 10);
      a    = 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      access(rd, wr, a, $urandom, d, l, hold);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(negedge clk);
    chk("cpu_queue_drained", cq.size(), 32'd0);
    chk("mem_queue_drained", mq.size(), 32'd0);
    finish_now();
  end

endmodule
